// File: rtl/display_dump_tx.sv
// display_dump_tx: streams a 16-character display buffer out of an 8N1
// UART transmitter, optionally followed by CR/LF, one request at a time.
module display_dump_tx #(
    parameter int CLK_FREQ    = 12000000,
    parameter int BAUD        = 115200,
    parameter int APPEND_CRLF = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dump_req,
    output logic       buf_rd_en,
    output logic [3:0] buf_rd_addr,
    input  logic [7:0] buf_rd_data,
    output logic       txd,
    output logic       busy,
    output logic       done
);

    // Rounded integer bit period; no fractional correction is attempted.
    localparam int DIV    = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int CW     = $clog2(DIV + 1);
    localparam int NCHARS = (APPEND_CRLF != 0) ? 18 : 16;

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   baud_cnt;
    logic [2:0]      bit_cnt;
    logic [4:0]      idx;
    logic [4:0]      fetch_idx;
    logic [7:0]      shreg;
    logic [7:0]      char_sel;
    logic            baud_tick;
    logic            last_char;

    // Next-state decode plus the character chosen for the current slot.
    always_comb begin
        state_nx  = state;
        baud_tick = (baud_cnt == CW'(DIV - 1));
        last_char = (idx == 5'(NCHARS - 1));
        // A new dump starts at index 0; later fetches advance by one.
        fetch_idx = (state == IDLE) ? 5'd0 : idx + 5'd1;
        if (idx < 5'd16) begin
            // Non-printable buffer bytes become '.' so the terminal stays sane.
            if (buf_rd_data < 8'h20 || buf_rd_data > 8'h7E)
                char_sel = 8'h2E;
            else
                char_sel = buf_rd_data;
        end else if (idx == 5'd16) begin
            char_sel = 8'h0D;
        end else begin
            char_sel = 8'h0A;
        end
        unique case (state)
            IDLE:    if (dump_req) state_nx = FETCH;
            FETCH:   state_nx = LOAD;
            LOAD:    state_nx = START;
            START:   if (baud_tick) state_nx = DATA;
            DATA:    if (baud_tick && bit_cnt == 3'd7) state_nx = STOP;
            STOP:    if (baud_tick) state_nx = last_char ? IDLE : FETCH;
            default: state_nx = IDLE;
        endcase
    end

    // State register and all datapath registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            txd         <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            buf_rd_en   <= 1'b0;
            buf_rd_addr <= 4'd0;
            idx         <= 5'd0;
            bit_cnt     <= 3'd0;
            baud_cnt    <= '0;
            shreg       <= 8'd0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx != IDLE);
            done  <= (state == STOP) && (state_nx == IDLE);

            // Read strobe is registered so it is high for the whole FETCH cycle;
            // CR/LF slots fetch nothing. The address holds between fetches.
            buf_rd_en <= (state_nx == FETCH) && (fetch_idx < 5'd16);
            if (state_nx == FETCH) begin
                idx         <= fetch_idx;
                buf_rd_addr <= fetch_idx[3:0];
            end

            // Baud counter runs only while a frame is on the wire.
            if ((state == START || state == DATA || state == STOP) && !baud_tick)
                baud_cnt <= baud_cnt + CW'(1);
            else
                baud_cnt <= '0;

            case (state)
                LOAD: begin
                    // Buffer data is valid only in this cycle.
                    shreg <= char_sel;
                    txd   <= 1'b0;
                end
                START: if (baud_tick) begin
                    txd     <= shreg[0];
                    shreg   <= {1'b0, shreg[7:1]};
                    bit_cnt <= 3'd0;
                end
                DATA: if (baud_tick) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        txd <= 1'b1;
                    end else begin
                        txd   <= shreg[0];
                        shreg <= {1'b0, shreg[7:1]};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_display_dump_tx.sv
// Bench for display_dump_tx: a timeline model of the serial stream checked
// every cycle, a software UART receiver, and literal expectations.
module tb_display_dump_tx;

    localparam int DIV = 104;
    localparam int CH  = 10 * DIV + 2;

    logic       clk = 1'b0;
    logic       rst_n, req_a, req_b;
    logic       en_a, en_b, txd_a, txd_b, busy_a, busy_b, done_a, done_b;
    logic [3:0] addr_a, addr_b;
    logic [7:0] rd_a, rd_b;
    logic [7:0] mem [16];
    logic [7:0] got [18];

    int vectors = 0, miscompares = 0, nprint = 0;
    int cyc = 0;
    bit chk_on = 1'b0;
    int done_a_cnt = 0, done_b_cnt = 0, done_b_cyc = 0, rd_b_cnt = 0;

    bit a_act = 1'b0, b_act = 1'b0;
    int a_t = 0, b_t = 0;

    always #5 clk = ~clk;

    display_dump_tx dut_a (
        .clk(clk), .rst_n(rst_n), .dump_req(req_a), .buf_rd_en(en_a),
        .buf_rd_addr(addr_a), .buf_rd_data(rd_a), .txd(txd_a), .busy(busy_a), .done(done_a)
    );

    display_dump_tx #(.APPEND_CRLF(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .dump_req(req_b), .buf_rd_en(en_b),
        .buf_rd_addr(addr_b), .buf_rd_data(rd_b), .txd(txd_b), .busy(busy_b), .done(done_b)
    );

    // Buffer memory: data valid one cycle after a strobe, garbage otherwise.
    always @(posedge clk) begin
        cyc  <= cyc + 1;
        rd_a <= (en_a === 1'b1) ? mem[addr_a] : 8'($urandom);
        rd_b <= (en_b === 1'b1) ? mem[addr_b] : 8'($urandom);
    end

    function automatic logic [7:0] exp_byte(int k);
        logic [7:0] d;
        if (k < 16) begin
            d = mem[k];
            return (d < 8'h20 || d > 8'h7E) ? 8'h2E : d;
        end
        return (k == 16) ? 8'h0D : 8'h0A;
    endfunction

    // Line level t cycles after the accepting edge of a dump of n characters.
    function automatic logic exp_txd(int t, int n);
        int u, k, r, b;
        logic [7:0] ch;
        if (t < 2) return 1'b1;
        u = t - 2; k = u / CH; r = u % CH; b = r / DIV;
        if (k >= n) return 1'b1;
        if (b == 0) return 1'b0;
        if (b <= 8) begin
            ch = exp_byte(k);
            return ch[b-1];
        end
        return 1'b1;
    endfunction

    task automatic step(input logic rst, input logic req, input int n, inout bit act, inout int t);
        if (!rst) act = 1'b0;
        else if (act && t < n * CH) t = t + 1;
        else if (req) begin act = 1'b1; t = 0; end
        else act = 1'b0;
    endtask

    always @(posedge clk) begin
        step(rst_n, req_a, 18, a_act, a_t);
        step(rst_n, req_b, 16, b_act, b_t);
    end

    task automatic cmp(input string nm, input bit act, input int t, input int n, input logic txd,
                       input logic busy, input logic done, input logic en, input logic [3:0] addr);
        logic e_txd, e_busy, e_done, e_en;
        e_txd = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_en = 1'b0;
        if (act) begin
            e_busy = (t < n * CH);
            e_done = (t == n * CH);
            e_en   = e_busy && (t % CH == 0) && (t / CH < 16);
            e_txd  = exp_txd(t, n);
        end
        vectors++;
        if (txd !== e_txd || busy !== e_busy || done !== e_done || en !== e_en ||
            (e_en && addr !== 4'(t / CH))) begin
            miscompares++;
            if (nprint < 30)
                $display("FAIL model_%s cyc=%0d t=%0d txd/busy/done/en/addr got %b%b%b%b %0d want %b%b%b%b %0d",
                         nm, cyc, t, txd, busy, done, en, addr, e_txd, e_busy, e_done, e_en, 4'(t / CH));
            nprint++;
        end
    endtask

    // Per-cycle compare against the model, plus pulse monitors.
    always @(negedge clk) begin
        if (chk_on) begin
            cmp("a", a_act, a_t, 18, txd_a, busy_a, done_a, en_a, addr_a);
            cmp("b", b_act, b_t, 16, txd_b, busy_b, done_b, en_b, addr_b);
        end
        if (done_a === 1'b1) done_a_cnt++;
        if (done_b === 1'b1) begin done_b_cnt++; done_b_cyc = cyc; end
        if (en_b === 1'b1) rd_b_cnt++;
    end

    task automatic check(input string nm, input int gotv, input int want);
        vectors++;
        if (gotv != want) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", nm, gotv, want);
        end
    endtask

    // Software receiver on dut_a; call at a negedge.
    task automatic rx_byte(output logic [7:0] b);
        int n;
        n = 0; b = 8'h00;
        while (txd_a === 1'b1 && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000) begin
            vectors++; miscompares++;
            $display("FAIL rx_start_timeout: got no start bit want one within 3000 cycles");
            return;
        end
        repeat (DIV / 2) @(negedge clk);
        check("rx_start_bit", int'(txd_a), 0);
        for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge clk);
            b[i] = txd_a;
        end
        repeat (DIV) @(negedge clk);
        check("rx_stop_bit", int'(txd_a), 1);
    endtask

    task automatic wait_done_a(input int e0, input int want);
        int n;
        n = 0;
        while (done_a !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        check("dump_a_length", cyc - e0, want);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        string h;
        int e0, n, dc;
        logic [7:0] b;

        // Test 1: request held through reset starts on the first released edge.
        h = "HELLO WORLD 1234";
        for (int k = 0; k < 16; k++) mem[k] = h[k];
        rst_n = 1'b0; req_a = 1'b1; req_b = 1'b1;
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        check("reset_txd", int'(txd_a), 1);
        check("reset_busy", int'(busy_a), 0);
        check("reset_done", int'(done_a), 0);
        check("reset_en", int'(en_a), 0);
        check("reset_addr", int'(addr_a), 0);
        rst_n = 1'b1;
        @(negedge clk);
        e0 = cyc;
        req_a = 1'b0; req_b = 1'b0;
        n = 0;
        while (txd_a === 1'b1 && n < 10) begin @(negedge clk); n++; end
        check("first_fall_delay", n, 2);
        for (int k = 0; k < 18; k++) rx_byte(got[k]);
        for (int k = 0; k < 16; k++) check("hello_char", int'(got[k]), int'(h[k]));
        check("hello_cr", int'(got[16]), 13);
        check("hello_lf", int'(got[17]), 10);
        wait_done_a(e0, 18756);
        check("dump_b_length", done_b_cyc - e0, 16672);
        check("b_rd_en_count", rd_b_cnt, 16);
        check("b_done_count", done_b_cnt, 1);
        repeat (3) @(negedge clk);

        // Test 2: substitution, ignored mid-dump requests, held request on B.
        h = " bcDEFghiJKLmno~";
        for (int k = 0; k < 16; k++) mem[k] = h[k];
        mem[3] = 8'h08; mem[9] = 8'h7F;
        dc = done_a_cnt;
        req_a = 1'b1; req_b = 1'b1;
        @(negedge clk);
        e0 = cyc;
        req_a = 1'b0;
        fork
            begin
                for (int k = 0; k < 18; k++) rx_byte(got[k]);
            end
            begin
                repeat (499) @(negedge clk);
                req_a = 1'b1; @(negedge clk); req_a = 1'b0;
                repeat (8499) @(negedge clk);
                req_a = 1'b1; @(negedge clk); req_a = 1'b0;
            end
            begin
                int m;
                m = 0;
                while (done_b !== 1'b1 && m < 20000) begin @(negedge clk); m++; end
                check("b_gap_busy", int'(busy_b), 0);
                @(negedge clk);
                check("b_rearm_busy", int'(busy_b), 1);
                req_b = 1'b0;
            end
        join
        for (int k = 0; k < 16; k++)
            check("subst_char", int'(got[k]), (k == 3 || k == 9) ? 46 : int'(h[k]));
        check("subst_cr", int'(got[16]), 13);
        check("subst_lf", int'(got[17]), 10);
        wait_done_a(e0, 18756);
        repeat (5) @(negedge clk);
        check("single_done_pulse", done_a_cnt - dc, 1);
        check("no_queued_dump", int'(busy_a), 0);

        // Test 3: one-cycle reset during bit 4 of character 7, then restart.
        req_a = 1'b1;
        @(negedge clk);
        e0 = cyc;
        req_a = 1'b0;
        repeat (7849) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid_txd", int'(txd_a), 1);
        check("rst_mid_busy", int'(busy_a), 0);
        dc = done_a_cnt;
        repeat (2000) @(negedge clk);
        check("rst_no_done", done_a_cnt - dc, 0);
        req_a = 1'b1;
        @(negedge clk);
        req_a = 1'b0;
        check("restart_addr", int'(addr_a), 0);
        rx_byte(b);
        check("restart_char0", int'(b), 32);
        rx_byte(b);
        check("restart_char1", int'(b), 98);
        repeat (60) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/display_dump_tx.md
DISPLAY_DUMP_TX -- requirements
Module: display_dump_tx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 12000000, giving the clk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200, giving the serial bit rate.
REQ-003 The block SHALL have parameter APPEND_CRLF, default 1; when 1, 0x0D then 0x0A follow the 16 buffer characters.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port dump_req, input, 1 bit: request to send the 16-character display buffer over serial.
REQ-007 The block SHALL have port buf_rd_en, output, 1 bit: read strobe to the display buffer.
REQ-008 The block SHALL have port buf_rd_addr, output, 4 bits: display buffer character index.
REQ-009 The block SHALL have port buf_rd_data, input, 8 bits: buffer byte, valid exactly 1 cycle after the edge that sampled buf_rd_en=1.
REQ-010 The block SHALL have port txd, output, 1 bit: serial line, 8N1, LSB first, idles high.
REQ-011 The block SHALL have port busy, output, 1 bit: high while a dump is in progress.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse when a dump completes.

Function
REQ-013 Bit period DIV SHALL be (CLK_FREQ + BAUD/2)/BAUD clk cycles (104 at defaults), fixed by an integer counter with no fractional accumulation.
REQ-014 FSM states SHALL be IDLE, FETCH, LOAD, START, DATA, STOP.
REQ-015 In IDLE, dump_req=1 at an edge SHALL set busy=1, char index=0 and state=FETCH at that edge.
REQ-016 FETCH SHALL last 1 cycle; buf_rd_addr=index; buf_rd_en=1 only if index<16 (0 for CR/LF slots).
REQ-017 LOAD SHALL last 1 cycle; on its ending edge the shift register loads the byte, txd goes 0, and the state becomes START.
REQ-018 Byte selection: index 0-15 uses buf_rd_data; index 16 uses 0x0D; index 17 uses 0x0A.
REQ-019 Buffer bytes below 0x20 or above 0x7E SHALL be sent as 0x2E ('.'); CR/LF are never substituted.
REQ-020 START, each of the 8 DATA bits, and STOP SHALL each hold txd for exactly DIV cycles; STOP drives txd=1.
REQ-021 At the end of STOP, if more characters remain, the index SHALL increment and the state SHALL become FETCH; otherwise the state SHALL become IDLE with busy=0 and done=1 for exactly that one following cycle.
REQ-022 Character count per dump SHALL be 18 when APPEND_CRLF=1 and 16 when it is 0.
REQ-023 Consecutive characters SHALL be spaced exactly 10*DIV+2 cycles start-to-start (2-cycle idle-high gap from FETCH+LOAD).
REQ-024 dump_req while busy=1 SHALL be ignored, with no queueing; dump_req on the same edge that done is asserted SHALL also be ignored.
REQ-025 dump_req held high SHALL start a new dump on the first IDLE edge after done, with at least 1 cycle of busy=0 between dumps.
REQ-026 buf_rd_addr SHALL hold its last value outside FETCH.
REQ-027 buf_rd_data SHALL be sampled only in LOAD; its value at all other times SHALL not affect txd.

Reset
REQ-028 rst_n=0 at an edge SHALL force state=IDLE, txd=1, busy=0, done=0, buf_rd_en=0, buf_rd_addr=0, index=0, bit and baud counters=0.
REQ-029 Reset mid-character SHALL truncate the frame, with txd high from the reset edge onward and no done pulse.
REQ-030 dump_req SHALL be ignored while rst_n=0; the first edge with rst_n=1 and dump_req=1 SHALL start a dump.

Verification
REQ-031 Buffer "HELLO WORLD 1234", dump_req pulse -> 18 frames "HELLO WORLD 1234\r\n", done after 18*1042=18756 cycles, busy high throughout.
REQ-032 Buffer with 0x08 at index 3 and 0x7F at index 9 -> bytes 3 and 9 decoded as 0x2E; all others unchanged.
REQ-033 Frame timing check -> txd falls 2 cycles after the dump_req edge, each bit is 104 cycles, and the inter-frame high gap is 106 cycles (stop bit + 2).
REQ-034 dump_req pulses at cycles 500 and 9000 during a dump -> exactly one dump and one done pulse.
REQ-035 rst_n low for 1 cycle during bit 4 of character 7 -> txd=1, busy=0, no done; a fresh dump_req then restarts from index 0.
REQ-036 APPEND_CRLF=0 -> 16 frames and done after 16672 cycles; buf_rd_en asserted exactly 16 times per dump.
